// File: rtl/ctr_record_buffer_if.sv
// ctr_record_buffer_if: record write ports, CSR controls and the CSR read port of the CTR record buffer.
interface ctr_record_buffer_if #(
  parameter int NR_PORTS = 2,
  parameter int DEPTH    = 16,
  parameter int XLEN     = 64,
  parameter int TYPE_W   = 4,
  parameter int CNT_W    = 16
);
  localparam int LW = $clog2(DEPTH);
  logic [NR_PORTS-1:0]            rec_valid_i;
  logic [NR_PORTS-1:0][XLEN-1:0]  rec_source_i;
  logic [NR_PORTS-1:0][XLEN-1:0]  rec_target_i;
  logic [NR_PORTS-1:0][TYPE_W-1:0] rec_type_i;
  logic                           freeze_i;
  logic                           clear_i;
  logic                           wrptr_we_i;
  logic [LW-1:0]                  wrptr_wdata_i;
  logic [LW-1:0]                  wrptr_o;
  logic [LW-1:0]                  rd_idx_i;
  logic                           rd_valid_o;
  logic [XLEN-1:0]                rd_source_o;
  logic [XLEN-1:0]                rd_target_o;
  logic [TYPE_W-1:0]              rd_type_o;
  logic [CNT_W-1:0]               rd_cc_o;
  logic                           rd_cc_sat_o;
  modport master (
    output rec_valid_i, rec_source_i, rec_target_i, rec_type_i,
    output freeze_i, clear_i, wrptr_we_i, wrptr_wdata_i, rd_idx_i,
    input  wrptr_o, rd_valid_o, rd_source_o, rd_target_o, rd_type_o, rd_cc_o, rd_cc_sat_o
  );
  modport slave (
    input  rec_valid_i, rec_source_i, rec_target_i, rec_type_i,
    input  freeze_i, clear_i, wrptr_we_i, wrptr_wdata_i, rd_idx_i,
    output wrptr_o, rd_valid_o, rd_source_o, rd_target_o, rd_type_o, rd_cc_o, rd_cc_sat_o
  );
endinterface

// File: rtl/ctr_record_buffer.sv
// ctr_record_buffer: circular Control Transfer Record storage read by logical index (0 = newest).
// Define CTR_CYCLE_COUNT_EN to keep the elapsed-cycle counter and per-entry cc/cc_sat fields.
module ctr_record_buffer #(
  parameter int NR_PORTS = 2,
  parameter int DEPTH    = 16,
  parameter int XLEN     = 64,
  parameter int TYPE_W   = 4,
  parameter int CNT_W    = 16
) (
  input logic clk_i,
  input logic rst_ni,
  ctr_record_buffer_if.slave bus
);
  localparam int LW = $clog2(DEPTH);
  logic [LW-1:0]     wrptr;
  logic [DEPTH-1:0]  vld;
  logic [XLEN-1:0]   src_q [DEPTH];
  logic [XLEN-1:0]   tgt_q [DEPTH];
  logic [TYPE_W-1:0] typ_q [DEPTH];
  logic [LW-1:0]     slot [NR_PORTS];
  logic [LW-1:0]     k;
  logic [LW-1:0]     rs;
  logic              wr;
  logic              rd_valid;
  logic [XLEN-1:0]   rd_source;
  logic [XLEN-1:0]   rd_target;
  logic [TYPE_W-1:0] rd_type;
  assign wr = ~bus.clear_i & ~bus.wrptr_we_i & ~bus.freeze_i;
  assign rs = wrptr - LW'(1) - bus.rd_idx_i;
  // Valid ports are packed into consecutive slots starting at wrptr.
  always_comb begin
    k = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      slot[p] = wrptr + k;
      k = k + LW'(bus.rec_valid_i[p]);
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wrptr     <= '0;
      vld       <= '0;
      rd_valid  <= 1'b0;
      rd_source <= '0;
      rd_target <= '0;
      rd_type   <= '0;
    end else begin
      rd_valid  <= vld[rs];
      rd_source <= vld[rs] ? src_q[rs] : '0;
      rd_target <= vld[rs] ? tgt_q[rs] : '0;
      rd_type   <= vld[rs] ? typ_q[rs] : '0;
      if (bus.clear_i) begin
        vld   <= '0;
        wrptr <= '0;
      end else if (bus.wrptr_we_i) begin
        wrptr <= bus.wrptr_wdata_i;
      end else if (!bus.freeze_i) begin
        wrptr <= wrptr + k;
        for (int p = 0; p < NR_PORTS; p++)
          if (bus.rec_valid_i[p]) vld[slot[p]] <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NR_PORTS; p++)
      if (wr && bus.rec_valid_i[p]) begin
        src_q[slot[p]] <= bus.rec_source_i[p];
        tgt_q[slot[p]] <= bus.rec_target_i[p];
        typ_q[slot[p]] <= bus.rec_type_i[p];
      end
  end
`ifdef CTR_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic [CNT_W-1:0] cc_q [DEPTH];
  logic [DEPTH-1:0] ccs_q;
  logic [CNT_W-1:0] rd_cc;
  logic             rd_cc_sat;
  logic             any_wr;
  assign any_wr = wr & |bus.rec_valid_i;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || bus.clear_i) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (!bus.freeze_i) begin
      cnt <= any_wr ? '0 : (&cnt ? cnt : cnt + CNT_W'(1));
      sat <= any_wr ? 1'b0 : (sat | &cnt);
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_cc     <= '0;
      rd_cc_sat <= 1'b0;
    end else begin
      rd_cc     <= vld[rs] ? cc_q[rs] : '0;
      rd_cc_sat <= vld[rs] & ccs_q[rs];
    end
  end
  // Only the first record of a cycle (the one landing at wrptr) carries the elapsed count.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NR_PORTS; p++)
      if (wr && bus.rec_valid_i[p]) begin
        cc_q[slot[p]]  <= slot[p] == wrptr ? cnt : '0;
        ccs_q[slot[p]] <= slot[p] == wrptr ? sat : 1'b0;
      end
  end
  assign bus.rd_cc_o     = rd_cc;
  assign bus.rd_cc_sat_o = rd_cc_sat;
`else
  assign bus.rd_cc_o     = '0;
  assign bus.rd_cc_sat_o = 1'b0;
`endif
  assign bus.wrptr_o     = wrptr;
  assign bus.rd_valid_o  = rd_valid;
  assign bus.rd_source_o = rd_source;
  assign bus.rd_target_o = rd_target;
  assign bus.rd_type_o   = rd_type;
endmodule
